// File: rtl/sar_search_4b_pkg.sv
// Shared types and defaults for the successive-approximation search block.
package sar_search_4b_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int SETTLE_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One sampled comparator response.
  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_t;

endpackage

// File: rtl/sar_search_4b.sv
// Binary search driven by an external magnitude comparator: probes guess,
// narrows [lo,hi] on lt/gt, stops on eq or on an inconsistent response.
module sar_search_4b
  import sar_search_4b_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int SETTLE = SETTLE_DEF,
  localparam int PW     = $clog2(WIDTH + 2),
  localparam int CW     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             eq,
  input  logic             lt,
  input  logic             gt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic [PW-1:0]    probes,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    probes_q, probes_d;
  logic             found_q, found_d;
  logic             err_q, err_d;
  cmp_t             cmp;

  // Midpoint with a carry bit so lo+hi never wraps.
  function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH:1];
  endfunction

  assign cmp = '{eq: eq, lt: lt, gt: gt};

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    probes_d = probes_q;
    found_d  = found_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PROBE;
          lo_d     = '0;
          hi_d     = '1;
          guess_d  = mid('0, '1);
          cnt_d    = '0;
          probes_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
        end
      end
      PROBE: begin
        if (cnt_q != CW'(SETTLE)) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          // Last cycle of the settle window: the comparator is trusted now.
          cnt_d    = '0;
          probes_d = probes_q + PW'(1);
          if (cmp == 3'b100) begin
            state_d  = DONE;
            found_d  = 1'b1;
            result_d = guess_q;
          end else if (cmp == 3'b010 && guess_q < hi_q) begin
            lo_d    = guess_q + WIDTH'(1);
            guess_d = mid(guess_q + WIDTH'(1), hi_q);
          end else if (cmp == 3'b001 && guess_q > lo_q) begin
            hi_d    = guess_q - WIDTH'(1);
            guess_d = mid(lo_q, guess_q - WIDTH'(1));
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      probes_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      probes_q <= probes_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = (state_q == PROBE);
  assign done   = (state_q == DONE);
  assign found  = found_q;
  assign result = result_q;
  assign probes = probes_q;
  assign err    = err_q;

endmodule
